// File: rtl/latsnq_bank_ctrl.sv
// Sequencer for a latch-row bank: turns write/preset requests into non-overlapping setup/enable/hold and set phases.
// Latency: a write takes PULSE_CYC+2 cycles after the handshake and a preset takes SET_CYC+1; done is raised in the last of those cycles.
// Backpressure: req_ready is high only in IDLE, and requests are ignored while a sequence is in flight.
module latsnq_bank_ctrl #(
  parameter int NUM_ROWS  = 8,
  parameter int AW        = 3,
  parameter int DW        = 8,
  parameter int PULSE_CYC = 2,
  parameter int SET_CYC   = 3
) (
  input  logic                CLK,
  input  logic                RN,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_op,
  input  logic [AW-1:0]       req_addr,
  input  logic [DW-1:0]       req_data,
  output logic [DW-1:0]       lat_d,
  output logic [NUM_ROWS-1:0] lat_e,
  output logic                lat_setn,
  output logic                done,
  output logic                err
);

  localparam int MAX_CYC = (PULSE_CYC > SET_CYC) ? PULSE_CYC : SET_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] SET_LD   = CW'(SET_CYC - 1);
  localparam logic [AW:0]   ROWS     = (AW + 1)'(NUM_ROWS);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_OPEN, S_HOLD, S_PRESET, S_RECOV
  } state_t;

  typedef struct packed {
    logic                ready;
    logic [NUM_ROWS-1:0] e;
    logic                setn;
    logic [DW-1:0]       d;
    logic                done;
    logic                err;
  } outs_t;

  state_t        state_q, state_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic [AW-1:0] addr_q;
  logic          boot_q;
  outs_t         out_q, out_nxt;
  logic          accept;
  logic          addr_bad;

  assign accept   = (state_q == S_IDLE) && req_valid;
  assign addr_bad = ({1'b0, addr_q} >= ROWS);

  // boot_q marks a reset-initiated preset so its RECOV cycle stays silent.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= S_PRESET;
      cnt_q   <= SET_LD;
      addr_q  <= '0;
      boot_q  <= 1'b1;
      out_q   <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      out_q   <= out_nxt;
      if (accept) addr_q <= req_addr;
      if (state_q == S_RECOV) boot_q <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_op) begin
            state_nxt = S_PRESET;
            cnt_nxt   = SET_LD;
          end else begin
            state_nxt = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        state_nxt = S_OPEN;
        cnt_nxt   = PULSE_LD;
      end
      S_OPEN: begin
        if (cnt_q == '0) state_nxt = S_HOLD;
        else             cnt_nxt   = cnt_q - CW'(1);
      end
      S_HOLD:  state_nxt = S_IDLE;
      S_PRESET: begin
        if (cnt_q == '0) state_nxt = S_RECOV;
        else             cnt_nxt   = cnt_q - CW'(1);
      end
      S_RECOV: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state so every pin comes straight from a flop.
  always_comb begin
    out_nxt       = out_q;
    out_nxt.ready = (state_nxt == S_IDLE);
    out_nxt.e     = '0;
    out_nxt.setn  = (state_nxt != S_PRESET);
    out_nxt.done  = (state_nxt == S_HOLD) || ((state_nxt == S_RECOV) && !boot_q);
    out_nxt.err   = (state_nxt == S_HOLD) && addr_bad;
    if (state_nxt == S_OPEN) begin
      for (int i = 0; i < NUM_ROWS; i++) begin
        out_nxt.e[i] = (addr_q == AW'(i));
      end
    end
    if (accept && !req_op) out_nxt.d = req_data;
  end

  assign req_ready = out_q.ready;
  assign lat_e     = out_q.e;
  assign lat_setn  = out_q.setn;
  assign lat_d     = out_q.d;
  assign done      = out_q.done;
  assign err       = out_q.err;

endmodule

// File: tb/tb_latsnq_bank_ctrl.sv
// Bench for latsnq_bank_ctrl: an 8-row and a 6-row instance share stimulus and are compared
// every cycle against a timeline model built from the request start cycle.
module tb_latsnq_bank_ctrl;

  localparam int P = 2;
  localparam int S = 3;

  localparam int K_IDLE   = 0;
  localparam int K_WRITE  = 1;
  localparam int K_PRESET = 2;
  localparam int K_BOOT   = 3;

  typedef struct packed {
    logic       ready;
    logic [7:0] e;
    logic [5:0] e6;
    logic       setn;
    logic [7:0] d;
    logic       done;
    logic       err;
    logic       err6;
  } obs_t;

  logic       CLK;
  logic       RN;
  logic       req_valid;
  logic       req_op;
  logic [2:0] req_addr;
  logic [7:0] req_data;
  logic       req_ready, req_ready6;
  logic [7:0] lat_d, lat_d6;
  logic [7:0] lat_e;
  logic [5:0] lat_e6;
  logic       lat_setn, lat_setn6;
  logic       done, done6;
  logic       err, err6;

  latsnq_bank_ctrl dut (
    .CLK(CLK), .RN(RN), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data), .lat_d(lat_d), .lat_e(lat_e),
    .lat_setn(lat_setn), .done(done), .err(err)
  );

  latsnq_bank_ctrl #(.NUM_ROWS(6)) dut6 (
    .CLK(CLK), .RN(RN), .req_valid(req_valid), .req_ready(req_ready6), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data), .lat_d(lat_d6), .lat_e(lat_e6),
    .lat_setn(lat_setn6), .done(done6), .err(err6)
  );

  obs_t obs, exp;
  assign obs = {req_ready, lat_e, lat_e6, lat_setn, lat_d, done, err, err6};

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit m_rst  = 1'b1;
  int m_kind = K_IDLE;
  int m_t0   = 0;
  int m_addr = 0;
  logic [7:0] m_d = 8'h00;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Expected pins for the current cycle, from the request's offset k = cyc - start cycle.
  function automatic obs_t model_out();
    obs_t o;
    int k;
    o = '0;
    if (m_rst) return o;
    o.setn = 1'b1;
    o.d    = m_d;
    k      = cyc - m_t0;
    case (m_kind)
      K_WRITE: begin
        if (k >= 2 && k <= 1 + P) begin
          o.e  = 8'd1 << m_addr;
          o.e6 = (m_addr < 6) ? 6'(1 << m_addr) : 6'd0;
        end else if (k == 2 + P) begin
          o.done = 1'b1;
          o.err6 = (m_addr >= 6);
        end else if (k >= 3 + P) begin
          o.ready = 1'b1;
        end
      end
      K_PRESET, K_BOOT: begin
        if (k <= S)          o.setn = 1'b0;
        else if (k == S + 1) o.done = (m_kind == K_PRESET);
        else                 o.ready = 1'b1;
      end
      default: o.ready = 1'b1;
    endcase
    return o;
  endfunction

  task automatic tick();
    @(negedge CLK);
    cyc++;
    exp = model_out();
  endtask

  task automatic drive(input logic v, input logic op, input logic [2:0] a,
                       input logic [7:0] dd, output bit acc);
    req_valid = v;
    req_op    = op;
    req_addr  = a;
    req_data  = dd;
    acc = v && exp.ready && !m_rst;
    if (acc) begin
      m_t0   = cyc;
      m_addr = int'(a);
      if (op) m_kind = K_PRESET;
      else begin
        m_kind = K_WRITE;
        m_d    = dd;
      end
    end
  endtask

  task automatic release_reset();
    @(posedge CLK);
    #2;
    RN     = 1'b1;
    m_rst  = 1'b0;
    m_kind = K_BOOT;
    m_t0   = cyc;
  endtask

  task automatic test_reset();
    bit acc;
    int lows = 0;
    bit saw_done = 1'b0;
    RN = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 8'h00, acc);
    tick();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reset_state cyc=%0d got=%h exp=%h", cyc, obs, exp);
    end
    checks++;
    if (lat_setn !== 1'b0 || lat_e !== 8'h00 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_pins setn=%b e=%h ready=%b required setn=0 e=00 ready=0", lat_setn, lat_e, req_ready);
    end
    release_reset();
    for (int k = 1; k <= S + 2; k++) begin
      tick();
      drive(1'b0, 1'b0, 3'd0, 8'h00, acc);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset_seq k=%0d got=%h exp=%h", k, obs, exp);
      end
      if (!lat_setn) lows++;
      if (done) saw_done = 1'b1;
    end
    checks++;
    if (lows !== S || saw_done || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release setn_low=%0d done_seen=%b ready=%b required %0d,0,1", lows, saw_done, req_ready, S);
    end
  endtask

  task automatic test_write();
    bit acc;
    tick();
    drive(1'b1, 1'b0, 3'd5, 8'hA5, acc);
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL write_accept ready=%b required 1", req_ready);
    end
    for (int k = 1; k <= P + 3; k++) begin
      tick();
      drive(1'b0, 1'b0, 3'd0, 8'h00, acc);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL write_seq k=%0d got=%h exp=%h", k, obs, exp);
      end
      if (k == 1) begin
        checks++;
        if (lat_d !== 8'hA5 || lat_e !== 8'h00) begin
          errors++;
          $display("FAIL write_setup d=%h e=%h required d=a5 e=00", lat_d, lat_e);
        end
      end else if (k <= P + 1) begin
        checks++;
        if (lat_e !== 8'b0010_0000 || lat_d !== 8'hA5) begin
          errors++;
          $display("FAIL write_open k=%0d e=%b d=%h required e=00100000 d=a5", k, lat_e, lat_d);
        end
      end else if (k == P + 2) begin
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || lat_e !== 8'h00) begin
          errors++;
          $display("FAIL write_done done=%b err=%b e=%h required 1,0,00", done, err, lat_e);
        end
      end else begin
        checks++;
        if (req_ready !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL write_ready ready=%b done=%b required 1,0", req_ready, done);
        end
      end
    end
  endtask

  task automatic test_preset();
    bit acc;
    int lows = 0;
    drive(1'b1, 1'b1, 3'd0, 8'h00, acc);
    for (int k = 1; k <= S + 2; k++) begin
      tick();
      drive(1'b0, 1'b0, 3'd0, 8'h00, acc);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL preset_seq k=%0d got=%h exp=%h", k, obs, exp);
      end
      if (!lat_setn) lows++;
      if (k == S + 1) begin
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || lat_setn !== 1'b1) begin
          errors++;
          $display("FAIL preset_recov done=%b err=%b setn=%b required 1,0,1", done, err, lat_setn);
        end
      end
    end
    checks++;
    if (lows !== S) begin
      errors++;
      $display("FAIL preset_width setn_low=%0d required %0d", lows, S);
    end
  endtask

  task automatic test_bad_addr();
    bit acc;
    drive(1'b1, 1'b0, 3'd7, 8'h3C, acc);
    for (int k = 1; k <= P + 3; k++) begin
      tick();
      drive(1'b0, 1'b0, 3'd0, 8'h00, acc);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL bad_addr_seq k=%0d got=%h exp=%h", k, obs, exp);
      end
      checks++;
      if (lat_e6 !== 6'd0) begin
        errors++;
        $display("FAIL bad_addr_enable k=%0d e6=%b required 000000", k, lat_e6);
      end
      if (k == P + 2) begin
        checks++;
        if (done6 !== 1'b1 || err6 !== 1'b1) begin
          errors++;
          $display("FAIL bad_addr_err done=%b err=%b required 1,1", done6, err6);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic       ops [3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0] adrs[3] = '{3'd2, 3'd0, 3'd0};
    logic [7:0] dats[3] = '{8'h11, 8'h00, 8'hFF};
    int acc_cyc[3];
    int done_cyc[$];
    int idx = 0;
    bit acc;
    bit prev_vld = 1'b0;
    logic [7:0] prev_e = '0;
    logic [7:0] prev_d = '0;
    for (int n = 0; n < 24; n++) begin
      tick();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL b2b_seq cyc=%0d got=%h exp=%h", cyc, obs, exp);
      end
      checks++;
      if ((|lat_e && !lat_setn) || $countones(lat_e) > 1) begin
        errors++;
        $display("FAIL b2b_enable_overlap e=%b setn=%b required onehot0 and no overlap", lat_e, lat_setn);
      end
      checks++;
      if (prev_vld && lat_d !== prev_d && (|lat_e || |prev_e)) begin
        errors++;
        $display("FAIL b2b_data_stable d=%h prev=%h required unchanged near enable", lat_d, prev_d);
      end
      if (done) done_cyc.push_back(cyc);
      if (idx < 3) drive(1'b1, ops[idx], adrs[idx], dats[idx], acc);
      else         drive(1'b0, 1'b0, 3'd0, 8'h00, acc);
      if (idx < 3 && req_ready) begin
        acc_cyc[idx] = cyc;
        idx++;
      end
      prev_vld = 1'b1;
      prev_e   = lat_e;
      prev_d   = lat_d;
    end
    checks++;
    if (idx !== 3 || done_cyc.size() !== 3) begin
      errors++;
      $display("FAIL b2b_count accepted=%0d dones=%0d required 3,3", idx, done_cyc.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (acc_cyc[i] !== done_cyc[i-1] + 1) begin
          errors++;
          $display("FAIL b2b_accept_gap req=%0d accepted=%0d required %0d", i, acc_cyc[i], done_cyc[i-1] + 1);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit acc;
    int lows = 0;
    bit saw_done = 1'b0;
    drive(1'b1, 1'b0, 3'd4, 8'h5A, acc);
    tick();
    drive(1'b0, 1'b0, 3'd0, 8'h00, acc);
    tick();
    checks++;
    if (lat_e !== 8'h10) begin
      errors++;
      $display("FAIL abort_open e=%h required 10", lat_e);
    end
    #1;
    RN    = 1'b0;
    m_rst = 1'b1;
    m_d   = 8'h00;
    #1;
    checks++;
    if (lat_e !== 8'h00 || lat_setn !== 1'b0 || lat_e6 !== 6'd0) begin
      errors++;
      $display("FAIL abort_async e=%h e6=%h setn=%b required 00,00,0", lat_e, lat_e6, lat_setn);
    end
    for (int n = 0; n < 2; n++) begin
      tick();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL abort_hold got=%h exp=%h", obs, exp);
      end
    end
    release_reset();
    for (int k = 1; k <= S + 3; k++) begin
      tick();
      drive(1'b0, 1'b0, 3'd0, 8'h00, acc);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL abort_recover k=%0d got=%h exp=%h", k, obs, exp);
      end
      if (!lat_setn) lows++;
      if (done || done6) saw_done = 1'b1;
    end
    checks++;
    if (lows !== S || saw_done) begin
      errors++;
      $display("FAIL abort_preset setn_low=%0d done_seen=%b required %0d,0", lows, saw_done, S);
    end
  endtask

  task automatic test_random();
    bit acc;
    bit prev_vld = 1'b0;
    logic [7:0] prev_e = '0;
    logic [7:0] prev_d = '0;
    for (int n = 0; n < 300; n++) begin
      tick();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL random_seq cyc=%0d got=%h exp=%h", cyc, obs, exp);
      end
      checks++;
      if ((|lat_e && !lat_setn) || $countones(lat_e) > 1) begin
        errors++;
        $display("FAIL random_enable e=%b setn=%b required onehot0 and no overlap", lat_e, lat_setn);
      end
      checks++;
      if (prev_vld && lat_d !== prev_d && (|lat_e || |prev_e)) begin
        errors++;
        $display("FAIL random_data_stable d=%h prev=%h required unchanged near enable", lat_d, prev_d);
      end
      prev_vld = 1'b1;
      prev_e   = lat_e;
      prev_d   = lat_d;
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
            3'($urandom_range(0, 7)), 8'($urandom), acc);
    end
  endtask

  initial begin
    RN        = 1'b0;
    req_valid = 1'b0;
    req_op    = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    exp       = '0;
    test_reset();
    test_write();
    test_preset();
    test_bad_addr();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
